// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: job control, weight/data/result handshakes and MAC core strobes.
// master is the sequencer side, slave is the surrounding buffer/core side.
interface mac_sequencer_if #(
    parameter int LANES   = 16,
    parameter int WADDR_W = 5
);
    logic               start;
    logic               abort;
    logic [WADDR_W-1:0] cfg_nweights;
    logic [7:0]         cfg_ndata;
    logic [3:0]         cfg_nrows;
    logic               w_valid;
    logic               w_ready;
    logic               d_valid;
    logic               d_ready;
    logic               res_valid;
    logic               res_ready;
    logic [3:0]         res_row;
    logic               we;
    logic               newdata;
    logic               comp;
    logic [WADDR_W-1:0] addr_weight;
    logic [3:0]         addr_result;
    logic [LANES-1:0]   addr_en;
    logic [LANES-1:0]   mac_clr;
    logic               busy;
    logic               done;
    logic [15:0]        perf_cycles;
    modport master (
        input  start, abort, cfg_nweights, cfg_ndata, cfg_nrows, w_valid, d_valid, res_ready,
        output w_ready, d_ready, res_valid, res_row, we, newdata, comp, addr_weight,
               addr_result, addr_en, mac_clr, busy, done, perf_cycles
    );
    modport slave (
        output start, abort, cfg_nweights, cfg_ndata, cfg_nrows, w_valid, d_valid, res_ready,
        input  w_ready, d_ready, res_valid, res_row, we, newdata, comp, addr_weight,
               addr_result, addr_en, mac_clr, busy, done, perf_cycles
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: turns weight/data/result handshakes into MAC core strobes for one job.
// Define MAC_SEQ_PERF_EN to get a saturating busy-cycle counter on perf_cycles.
module mac_sequencer #(
    parameter int LANES    = 16,
    parameter int WADDR_W  = 5,
    parameter int PIPE_LAT = 3,
    parameter int RD_LAT   = 2
) (
    input logic Clk,
    input logic reset_n,
    mac_sequencer_if.master bus
);
    typedef enum logic [3:0] {IDLE, CLEAR, LOAD, STREAM, DRAIN, READ, WAIT, RESULT, DONE} state_t;
    localparam logic [7:0] DRAIN_END = 8'(PIPE_LAT - 1);
    localparam logic [7:0] WAIT_END  = 8'(RD_LAT - 1);
    state_t             state;
    logic [WADDR_W-1:0] nw, wcnt, widx;
    logic [7:0]         nd, dcnt, lcnt;
    logic [3:0]         nr, rcnt;
    // Strobes are registered, so each one appears the cycle after the beat it acknowledges.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            nw               <= '0;
            nd               <= '0;
            nr               <= '0;
            wcnt             <= '0;
            widx             <= '0;
            dcnt             <= '0;
            rcnt             <= '0;
            lcnt             <= '0;
            bus.w_ready      <= 1'b0;
            bus.d_ready      <= 1'b0;
            bus.res_valid    <= 1'b0;
            bus.res_row      <= '0;
            bus.we           <= 1'b0;
            bus.newdata      <= 1'b0;
            bus.comp         <= 1'b0;
            bus.addr_weight  <= '0;
            bus.addr_result  <= '0;
            bus.addr_en      <= '0;
            bus.mac_clr      <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.we      <= 1'b0;
            bus.newdata <= 1'b0;
            bus.comp    <= 1'b0;
            bus.done    <= 1'b0;
            bus.mac_clr <= '0;
            if (state != IDLE && bus.abort) begin
                state         <= IDLE;
                bus.mac_clr   <= {LANES{1'b1}};
                bus.w_ready   <= 1'b0;
                bus.d_ready   <= 1'b0;
                bus.res_valid <= 1'b0;
                bus.addr_en   <= '0;
                bus.busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        nw          <= bus.cfg_nweights;
                        nd          <= bus.cfg_ndata;
                        nr          <= bus.cfg_nrows;
                        wcnt        <= '0;
                        widx        <= '0;
                        dcnt        <= '0;
                        rcnt        <= '0;
                        lcnt        <= '0;
                        state       <= CLEAR;
                        bus.mac_clr <= {LANES{1'b1}};
                        bus.busy    <= 1'b1;
                    end
                    CLEAR: begin
                        state       <= LOAD;
                        bus.w_ready <= 1'b1;
                    end
                    LOAD: if (bus.w_valid && bus.w_ready) begin
                        bus.we          <= 1'b1;
                        bus.addr_weight <= wcnt;
                        wcnt            <= wcnt + 1'b1;
                        if (wcnt == nw) begin
                            state       <= STREAM;
                            bus.w_ready <= 1'b0;
                            bus.d_ready <= 1'b1;
                            bus.addr_en <= {LANES{1'b1}};
                        end
                    end
                    STREAM: if (bus.d_valid && bus.d_ready) begin
                        bus.newdata     <= 1'b1;
                        bus.addr_weight <= widx;
                        widx            <= (widx == nw) ? '0 : widx + 1'b1;
                        dcnt            <= dcnt + 8'd1;
                        if (dcnt == nd) begin
                            state       <= DRAIN;
                            bus.d_ready <= 1'b0;
                            bus.addr_en <= '0;
                            lcnt        <= '0;
                        end
                    end
                    DRAIN: if (lcnt == DRAIN_END) begin
                        state           <= READ;
                        bus.comp        <= 1'b1;
                        bus.addr_result <= rcnt;
                    end else begin
                        lcnt <= lcnt + 8'd1;
                    end
                    READ: begin
                        state <= WAIT;
                        lcnt  <= '0;
                    end
                    WAIT: if (lcnt == WAIT_END) begin
                        state         <= RESULT;
                        bus.res_valid <= 1'b1;
                        bus.res_row   <= rcnt;
                    end else begin
                        lcnt <= lcnt + 8'd1;
                    end
                    RESULT: if (bus.res_valid && bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        if (rcnt == nr) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state           <= READ;
                            rcnt            <= rcnt + 4'd1;
                            bus.comp        <= 1'b1;
                            bus.addr_result <= rcnt + 4'd1;
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`ifdef MAC_SEQ_PERF_EN
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            bus.perf_cycles <= '0;
        else if (state == IDLE && bus.start)
            bus.perf_cycles <= '0;
        else if (bus.busy && bus.perf_cycles != 16'hFFFF)
            bus.perf_cycles <= bus.perf_cycles + 16'd1;
    end
`else
    assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized jobs checked cycle by cycle against a job-level timing model.
module tb_mac_sequencer;
    localparam int LANES    = 16;
    localparam int WADDR_W  = 5;
    localparam int PIPE_LAT = 3;
    localparam int RD_LAT   = 2;
    localparam logic [LANES-1:0] ALL = {LANES{1'b1}};
`ifdef MAC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic Clk = 1'b0;
    logic reset_n = 1'b0;
    int errors = 0;
    int checks = 0;
    mac_sequencer_if #(.LANES(LANES), .WADDR_W(WADDR_W)) sif ();
    mac_sequencer #(.LANES(LANES), .WADDR_W(WADDR_W), .PIPE_LAT(PIPE_LAT), .RD_LAT(RD_LAT)) dut (
        .Clk(Clk),
        .reset_n(reset_n),
        .bus(sif)
    );
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    // Model: cycle t=0 is the start cycle; readiness and strobe timing follow from beat counts.
    task automatic run_job(input int nw, input int nd, input int nr, input int pv, input int srow,
                           input int sn, input int ab, input int sa, input int elen);
        int t, wa, da, ra, t_comp, t_res, t_done, stall, n_we, n_nd, n_comp, e_wa, e_da;
        logic wacc, dacc, racc, abt, e_wr, e_dr, e_rv, e_we, e_nd;
        @(negedge Clk);
        sif.cfg_nweights = WADDR_W'(nw);
        sif.cfg_ndata = 8'(nd);
        sif.cfg_nrows = 4'(nr);
        sif.start = 1'b1;
        sif.abort = (sa != 0);
        sif.w_valid = 1'b0;
        sif.d_valid = 1'b0;
        sif.res_ready = 1'b0;
        t = 0; wa = 0; da = 0; ra = 0; t_comp = -1; t_res = -1; t_done = -1; stall = 0;
        n_we = 0; n_nd = 0; n_comp = 0;
        wacc = 1'b0; dacc = 1'b0; racc = 1'b0; abt = 1'b0;
        while (t < 3000 && t_done < 0) begin
            @(negedge Clk);
            t++;
            e_we = wacc;
            e_wa = wa;
            e_nd = dacc;
            e_da = da % (nw + 1);
            if (wacc) wa++;
            if (dacc) begin
                da++;
                if (da == nd + 1) t_comp = t + PIPE_LAT;
            end
            if (racc) begin
                ra++;
                t_res = -1;
                if (ra == nr + 1) t_done = t;
                else t_comp = t;
            end
            if (t == t_comp) t_res = t + RD_LAT + 1;
            if (abt) begin
                chk("abort_busy", 32'(sif.busy), 0);
                chk("abort_clr", 32'(sif.mac_clr), 32'(ALL));
                chk("abort_ready", 32'({sif.w_ready, sif.d_ready, sif.res_valid}), 0);
                chk("abort_strobe", 32'({sif.we, sif.newdata, sif.comp, sif.done}), 0);
                chk("abort_en", 32'(sif.addr_en), 0);
                sif.start = 1'b0;
                sif.abort = 1'b0;
                sif.w_valid = 1'b0;
                sif.d_valid = 1'b0;
                @(negedge Clk);
                chk("post_abort_clr", 32'(sif.mac_clr), 0);
                chk("post_abort_done", 32'(sif.done), 0);
                chk("post_abort_busy", 32'(sif.busy), 0);
                return;
            end
            e_wr = (t >= 2) && (wa <= nw);
            e_dr = (wa == nw + 1) && (da <= nd);
            e_rv = (t_res >= 0) && (t >= t_res);
            chk("w_ready", 32'(sif.w_ready), 32'(e_wr));
            chk("d_ready", 32'(sif.d_ready), 32'(e_dr));
            chk("addr_en", 32'(sif.addr_en), 32'(e_dr ? ALL : {LANES{1'b0}}));
            chk("we", 32'(sif.we), 32'(e_we));
            chk("newdata", 32'(sif.newdata), 32'(e_nd));
            chk("comp", 32'(sif.comp), 32'(t == t_comp));
            chk("res_valid", 32'(sif.res_valid), 32'(e_rv));
            chk("done", 32'(sif.done), 32'(t == t_done));
            chk("busy", 32'(sif.busy), 1);
            chk("mac_clr", 32'(sif.mac_clr), 32'((t == 1) ? ALL : {LANES{1'b0}}));
            chk("perf_run", 32'(sif.perf_cycles), PERF ? t - 1 : 0);
            if (e_we) chk("we_addr", 32'(sif.addr_weight), e_wa);
            if (e_nd) chk("newdata_addr", 32'(sif.addr_weight), e_da);
            if (t == t_comp) chk("comp_addr", 32'(sif.addr_result), ra);
            if (e_rv) chk("res_row", 32'(sif.res_row), ra);
            if (sif.we === 1'b1) n_we++;
            if (sif.newdata === 1'b1) n_nd++;
            if (sif.comp === 1'b1) n_comp++;
            sif.start = 1'($urandom_range(0, 1));
            sif.cfg_nweights = WADDR_W'($urandom);
            sif.cfg_ndata = 8'($urandom);
            sif.cfg_nrows = 4'($urandom);
            sif.w_valid = ($urandom_range(1, 100) <= pv);
            sif.d_valid = ($urandom_range(1, 100) <= pv);
            if (e_rv && ra == srow && stall < sn) begin
                sif.res_ready = 1'b0;
                stall++;
            end else begin
                sif.res_ready = ($urandom_range(1, 100) <= pv);
            end
            sif.abort = (ab >= 0) && e_dr && (da == ab);
            abt = sif.abort;
            if (abt) sif.d_valid = 1'b1;
            wacc = !abt && sif.w_valid && e_wr;
            dacc = !abt && sif.d_valid && e_dr;
            racc = !abt && sif.res_ready && e_rv;
        end
        chk("timeout", 32'(t_done >= 0), 1);
        if (elen > 0) chk("job_len", t_done + 1, elen);
        chk("we_count", n_we, nw + 1);
        chk("newdata_count", n_nd, nd + 1);
        chk("comp_count", n_comp, nr + 1);
        sif.start = 1'b0;
        sif.abort = 1'b0;
        sif.w_valid = 1'b0;
        sif.d_valid = 1'b0;
        @(negedge Clk);
        chk("idle_busy", 32'(sif.busy), 0);
        chk("idle_done", 32'(sif.done), 0);
        chk("perf_hold", 32'(sif.perf_cycles), PERF ? t_done : 0);
    endtask

    initial begin
        sif.start = 1'b0;
        sif.abort = 1'b0;
        sif.cfg_nweights = '0;
        sif.cfg_ndata = '0;
        sif.cfg_nrows = '0;
        sif.w_valid = 1'b0;
        sif.d_valid = 1'b0;
        sif.res_ready = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_strobes", 32'({sif.we, sif.newdata, sif.comp, sif.done}), 0);
        chk("rst_ready", 32'({sif.w_ready, sif.d_ready, sif.res_valid, sif.busy}), 0);
        chk("rst_addr_weight", 32'(sif.addr_weight), 0);
        chk("rst_addr_result", 32'(sif.addr_result), 0);
        chk("rst_res_row", 32'(sif.res_row), 0);
        chk("rst_addr_en", 32'(sif.addr_en), 0);
        chk("rst_mac_clr", 32'(sif.mac_clr), 0);
        chk("rst_perf", 32'(sif.perf_cycles), 0);
        reset_n = 1'b1;
        run_job(0, 0, 0, 100, -1, 0, -1, 0, 12);
        run_job(0, 0, 0, 100, -1, 0, -1, 1, 12);
        run_job(3, 9, 0, 100, -1, 0, -1, 0, -1);
        for (int k = 0; k < 4; k++)
            run_job($urandom_range(0, 7), $urandom_range(0, 20), $urandom_range(0, 3), 50, -1, 0, -1, 0, -1);
        run_job(1, 3, 15, 100, 7, 3, -1, 0, -1);
        run_job(2, 20, 1, 100, -1, 0, 5, 0, -1);
        @(negedge Clk);
        sif.cfg_nweights = 5'd7;
        sif.cfg_ndata = 8'd3;
        sif.cfg_nrows = 4'd0;
        sif.start = 1'b1;
        sif.w_valid = 1'b1;
        @(negedge Clk);
        sif.start = 1'b0;
        repeat (4) @(negedge Clk);
        chk("pre_rst_we", 32'(sif.we), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(sif.busy), 0);
        chk("arst_we", 32'(sif.we), 0);
        chk("arst_w_ready", 32'(sif.w_ready), 0);
        chk("arst_addr_weight", 32'(sif.addr_weight), 0);
        chk("arst_mac_clr", 32'(sif.mac_clr), 0);
        @(negedge Clk);
        reset_n = 1'b1;
        sif.w_valid = 1'b0;
        @(negedge Clk);
        chk("post_arst_clr", 32'(sif.mac_clr), 0);
        chk("post_arst_busy", 32'(sif.busy), 0);
        run_job(0, 0, 0, 100, -1, 0, -1, 0, 12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control sequencer driving the 16-lane MAC core: it initiates every weight write, data beat and result read the core needs. Upstream weight/data streams arrive on valid/ready handshakes. The sequencer converts them into the core's WE/NEWDATA/COMP/address strobes, waits out the core's pipeline, then returns each result row on a valid/ready handshake. It sits between the DMA/buffer layer and the MAC core.

## Interface
- LANES, 16, MAC lanes; width of lane enable/clear vectors
- WADDR_W, 5, weight slot address width (32 slots per lane)
- PIPE_LAT, 3, cycles from last NEWDATA to a stable MAC accumulator
- RD_LAT, 2, cycles from COMP to a valid core dataOut
- Clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  job start; sampled only in IDLE
- abort  in  1  synchronous abort; honoured in any non-IDLE state
- cfg_nweights  in  WADDR_W  weight slots to load, minus 1
- cfg_ndata  in  8  data beats to stream, minus 1
- cfg_nrows  in  4  result rows to read, minus 1
- w_valid / w_ready  in / out  1  weight beat handshake
- d_valid / d_ready  in / out  1  data beat handshake
- res_valid / res_ready  out / in  1  result row handshake
- res_row  out  4  index of the row presented with res_valid
- we, newdata, comp  out  1  MAC core strobes
- addr_weight  out  WADDR_W  broadcast weight slot address
- addr_result  out  4  result row select
- addr_en  out  LANES  lane enables; all ones during STREAM, else 0
- mac_clr  out  LANES  per-lane clear to core
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on job completion
- perf_cycles  out  16  job cycle count (see Configuration)

## Operation
- FSM states: IDLE, CLEAR, LOAD, STREAM, DRAIN, READ, WAIT, RESULT, DONE.
- IDLE: on start, latch all cfg_* fields, go to CLEAR. cfg_* changes after latch have no effect.
- CLEAR: mac_clr all ones for exactly 1 cycle, counters zeroed, go to LOAD.
- LOAD: w_ready=1. Each w_valid&&w_ready: we=1, addr_weight=wcnt, wcnt++. The beat with wcnt==cfg_nweights goes to STREAM.
- STREAM: d_ready=1. Each accepted beat: newdata=1, addr_weight=dcnt mod (cfg_nweights+1), dcnt++. The beat with dcnt==cfg_ndata goes to DRAIN.
- A cycle with no accepted beat in LOAD or STREAM drives we=0 and newdata=0.
- DRAIN: count PIPE_LAT cycles, then go to READ.
- READ: comp=1, addr_result=rcnt for 1 cycle, go to WAIT.
- WAIT: count RD_LAT cycles, go to RESULT.
- RESULT: res_valid=1, res_row=rcnt, held stable until res_ready.
  - On handshake, if rcnt==cfg_nrows go to DONE; else rcnt++ and go to READ.
- DONE: done=1 for 1 cycle, go to IDLE.
- abort: next state IDLE, with mac_clr all ones for that one cycle. All handshakes drop, and a beat offered in the abort cycle is not accepted. abort overrides a simultaneous handshake.
- start while busy is ignored. start and abort together in IDLE: start wins.

## Timing
- Reset values:
  - state IDLE; all counters 0.
  - we, newdata, comp, w_ready, d_ready, res_valid, busy, done = 0.
  - addr_weight, addr_result, res_row, addr_en, mac_clr, perf_cycles = 0.
- All outputs are registered.
- start→first w_ready: 2 cycles (IDLE→CLEAR→LOAD).
- Last data beat→first comp: PIPE_LAT+1 cycles. comp→res_valid: RD_LAT+1 cycles.
- Minimum job length (1 weight, 1 data, 1 row, zero stalls): 1+1+1+1+PIPE_LAT+1+RD_LAT+1+1 = 12 cycles with defaults.
- Asynchronous reset mid-job forces reset values immediately. No mac_clr pulse is issued; the next job's CLEAR covers it.

## Configuration
- MAC_SEQ_PERF_EN defined:
  - perf_cycles clears on start and increments every busy cycle, saturating at 16'hFFFF.
  - The value holds after done until the next start.
- Undefined: perf_cycles is tied to 0 and no counter logic is generated.

## Test plan
- Minimal job, cfg 0/0/0, all valids held high, res_ready=1 → done exactly 12 cycles after start; one result with res_row=0.
- Load 4 weights (cfg_nweights=3), stream 10 beats → addr_weight on newdata cycles is 0,1,2,3,0,1,2,3,0,1; we asserted on exactly 4 cycles with addr_weight 0..3.
- Random w_valid/d_valid gaps (50%) → we/newdata count equals accepted beats; no strobe on a stall cycle.
- cfg_nrows=15 with res_ready low for 3 cycles on row 7 → res_row/res_valid held; rows 0..15 delivered in order; comp asserted exactly 16 times.
- abort during STREAM after 5 beats → next cycle state IDLE, mac_clr=16'hFFFF for 1 cycle, busy=0, no done pulse.
- With MAC_SEQ_PERF_EN, minimal job → perf_cycles=11 after done; a second start clears it.
